// File: rtl/mulvec_pkg.sv
// mulvec_pkg: shared state/op encodings and plane indexing for the bit-sliced multiplier
package mulvec_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic {OP_MUL = 1'b0, OP_SQR = 1'b1} op_e;
   function automatic int plane_idx(input int k, input int lanes);
      return k * lanes;
   endfunction
endpackage

// File: rtl/mulvec_seq_if.sv
// mulvec_seq_if: operand/result valid-ready bus in bit-plane layout
interface mulvec_seq_if #(
   parameter int LANES = 16,
   parameter int NBITS = 2
);
   import mulvec_pkg::*;
   logic                     in_valid;
   logic                     in_ready;
   op_e                      op;
   logic [NBITS*LANES-1:0]   a_pl;
   logic [NBITS*LANES-1:0]   b_pl;
   logic                     out_valid;
   logic                     out_ready;
   logic [2*NBITS*LANES-1:0] y_pl;
   modport master (output in_valid, op, a_pl, b_pl, out_ready, input in_ready, out_valid, y_pl);
   modport slave (input in_valid, op, a_pl, b_pl, out_ready, output in_ready, out_valid, y_pl);
endinterface

// File: rtl/bitslice_add.sv
// bitslice_add: per-lane ripple adder across plane words, carry-out exposed for checking
module bitslice_add #(
   parameter int LANES = 16,
   parameter int WIDTH = 4
) (
   input  logic [WIDTH*LANES-1:0] x_i,
   input  logic [WIDTH*LANES-1:0] y_i,
   output logic [WIDTH*LANES-1:0] s_o,
   output logic [LANES-1:0]       c_o
);
   logic [LANES-1:0] c;
   logic [LANES-1:0] x;
   logic [LANES-1:0] y;
   always_comb begin
      s_o = '0;
      c = '0;
      x = '0;
      y = '0;
      for (int j = 0; j < WIDTH; j++) begin
         x = x_i[j*LANES +: LANES];
         y = y_i[j*LANES +: LANES];
         s_o[j*LANES +: LANES] = x ^ y ^ c;
         c = (x & y) | (x & c) | (y & c);
      end
   end
   assign c_o = c;
endmodule

// File: rtl/mulvec_seq.sv
// mulvec_seq: LANES parallel NBITS x NBITS unsigned multiplies, one shift-add plane step per clock
module mulvec_seq import mulvec_pkg::*; #(
   parameter int LANES = 16,
   parameter int NBITS = 2
) (
   input logic         clk,
   input logic         rst_n,
   mulvec_seq_if.slave bus
);
   localparam int PW = NBITS * LANES;
   localparam int YW = 2 * PW;
   localparam int CW = NBITS > 1 ? $clog2(NBITS) : 1;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   a_q, a_d, b_q, b_d, part;
   logic [YW-1:0]   acc_q, acc_d, y_q, y_d, addend, sum;
   logic            ov_q, ov_d, accept, last;
   logic [LANES-1:0] b_k, cout;

   assign bus.in_ready  = state_q == IDLE || (state_q == DONE && bus.out_ready);
   assign bus.out_valid = ov_q;
   assign bus.y_pl      = y_q;
   assign accept        = bus.in_valid && bus.in_ready;
   assign last          = cnt_q == CW'(NBITS - 1);
   assign b_k           = b_q[plane_idx(int'(cnt_q), LANES) +: LANES];

   // partial product row for b bit k, placed k planes up
   always_comb begin
      part = '0;
      for (int i = 0; i < NBITS; i++)
         part[plane_idx(i, LANES) +: LANES] = a_q[plane_idx(i, LANES) +: LANES] & b_k;
   end
   assign addend = {{PW{1'b0}}, part} << plane_idx(int'(cnt_q), LANES);

   bitslice_add #(.LANES(LANES), .WIDTH(2 * NBITS)) u_add (
      .x_i(acc_q),
      .y_i(addend),
      .s_o(sum),
      .c_o(cout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      y_d     = y_q;
      ov_d    = ov_q;
      unique case (state_q)
         RUN: begin
            acc_d = sum;
            cnt_d = last ? cnt_q : cnt_q + CW'(1);
            if (last) begin
               y_d     = sum;
               ov_d    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: if (bus.out_ready) begin
            ov_d    = 1'b0;
            state_d = IDLE;
         end
         default: ;
      endcase
      // an accept in DONE overrides the return to IDLE
      if (accept) begin
         a_d     = bus.a_pl;
         b_d     = bus.op == OP_SQR ? bus.a_pl : bus.b_pl;
         acc_d   = '0;
         cnt_d   = '0;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         y_q     <= y_d;
         ov_q    <= ov_d;
      end
   end

   a_no_carry_out: assert property (@(posedge clk) disable iff (!rst_n) state_q == RUN |-> cout == '0);
endmodule

// File: doc/mulvec_seq.md
# mulvec_seq

Bit-sliced, sequential vector multiplier. The parametrised successor of the combinational 2-bit × 2-bit, 16-lane mul4 vector individuals. It computes LANES independent NBITS × NBITS unsigned products, or squares, in bit-plane layout, using one shift-add step per clock. It sits behind the tournament evaluator as the golden and throughput reference, with valid/ready handshakes on both sides.

## Interface
Parameters:
- LANES, 16: independent lanes; one bit per lane in every plane.
- NBITS, 2: operand width per lane; the product is 2*NBITS bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands are presented.
- in_ready  out  1  block accepts operands this cycle.
- op  in  1  0 = a*b, 1 = a*a (b ignored); sampled with the operands.
- a_pl  in  NBITS*LANES  plane k = [k*LANES +: LANES], bit k of every lane's a.
- b_pl  in  NBITS*LANES  same layout for b.
- out_valid  out  1  result is held on y_pl.
- out_ready  in  1  consumer takes the result.
- y_pl  out  2*NBITS*LANES  product planes; plane k = bit k of every lane's product.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state = IDLE, out_valid = 0, y_pl = 0, step counter = 0, accumulator = 0. in_ready is 1 while rst_n is low.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept on a clock edge where in_valid && in_ready:
  - latch a_pl, b_pl, and op (if op=1, latch b := a);
  - clear the accumulator and the counter;
  - go to RUN.
- Each RUN edge with counter = k:
  - addend plane j = a plane (j-k) & b plane k, for k ≤ j < k+NBITS; all other planes are 0;
  - accumulator := accumulator + addend, with a ripple carry across 2*NBITS planes, per lane;
  - counter++.
- On the RUN edge where k = NBITS-1: load the final sum into y_pl, set out_valid = 1, go to DONE.
- Overflow cannot occur: the maximum product fits in 2*NBITS bits. A carry out of the top plane is a design error, and an assertion checks it.
- DONE:
  - y_pl and out_valid are held stable while out_ready = 0.
  - On out_ready: out_valid clears. If in_valid is also high that cycle, the new operands are accepted on the same edge and the state goes directly to RUN; otherwise it goes to IDLE.
- y_pl keeps its last value after out_valid drops. It updates only on the final RUN edge.
- Reset mid-operation: immediate return to the reset values. The in-flight result is discarded and out_valid is never asserted for it.
- Lanes never interact. All per-lane logic is bitwise AND/XOR/OR across plane words.

## Timing
- Latency: accept at edge T; out_valid is high after edge T+NBITS (NBITS RUN edges).
- Maximum throughput with out_ready tied high: one result per NBITS+1 cycles.
- There are no combinational paths from in_valid or operands to any output.
- The only combinational input-to-output path is out_ready -> in_ready.

## Structure
- Package mulvec_pkg:
  - state enum (IDLE, RUN, DONE);
  - op enum (OP_MUL = 0, OP_SQR = 1);
  - function plane_idx(k, LANES).
- Sub-module bitslice_add, parametrised by LANES and WIDTH:
  - combinational ripple adder over plane arrays;
  - sum = x ^ y ^ c, carry = majority(x, y, c);
  - outputs the carry-out for the assertion.
- Expected RTL size is about 200 lines total.

## Test plan
- **Exhaustive 2-bit** (NBITS=2, LANES=16): a_pl = {FF00, F0F0}, b_pl = {CCCC, AAAA}, op=0 -> y_pl planes 3..0 = {8000, 4C00, 6AC0, A0A0}. out_valid rises exactly 2 edges after accept.
- **Square mode**: a_pl = {FFFF, FFFF}, b_pl = random, op=1 -> planes 3..0 = {FFFF, 0000, 0000, FFFF} (3*3 = 9 in every lane).
- **Backpressure**: hold out_ready=0 for 5 cycles after out_valid. y_pl is stable, in_ready=0 throughout, and there is exactly one transfer when out_ready rises.
- **Back-to-back**: out_ready=1 and in_valid=1 in DONE. The next operation is accepted on the same edge, giving one result every 3 cycles over 4 operations, each matching the reference model.
- **Reset mid-RUN**: assert rst_n=0 after the first RUN edge. out_valid=0, y_pl=0, state IDLE. A following operation produces the correct result.
- **Wide config** (NBITS=4, LANES=8): all lanes a=15, b=15 -> product 225 (0xE1). Planes 0, 5, 6, 7 = FF, all others 00. Latency is 4 edges.
